// File: rtl/mult_pkg.sv
// mult_pkg: shared constants and partial-product row type for the Wallace multiplier
package mult_pkg;
    localparam int W_DEF = 8;
    localparam int LATENCY = 3;
    localparam int MAX_W = 16;
    typedef logic [2*MAX_W-1:0] pp_row_t;
endpackage

// File: rtl/wallace_reduce.sv
// wallace_reduce: combinational 3:2 carry-save tree folding W partial-product rows into sum and carry rows
module wallace_reduce
    import mult_pkg::*;
#(
    parameter int W = W_DEF,
    parameter int OUT_W = 2 * W
) (
    input  pp_row_t          pp [W],
    output logic [OUT_W-1:0] sum,
    output logic [OUT_W-1:0] carry
);
    logic [OUT_W-1:0] r  [W];
    logic [OUT_W-1:0] nx [W];
    int n, m;
    always_comb begin
        for (int i = 0; i < W; i++) r[i] = pp[i][OUT_W-1:0];
        n = W;
        m = 0;
        // each level compresses every group of three rows into two; leftovers pass through
        for (int l = 0; l < 8; l++) begin
            for (int i = 0; i < W; i++) nx[i] = '0;
            m = 0;
            for (int g = 0; g < W; g += 3) begin
                if (g + 2 < n) begin
                    nx[m] = r[g] ^ r[g+1] ^ r[g+2];
                    nx[m+1] = ((r[g] & r[g+1]) | (r[g] & r[g+2]) | (r[g+1] & r[g+2])) << 1;
                    m = m + 2;
                end else begin
                    for (int k = 0; k < 2; k++) begin
                        if (g + k < n) begin
                            nx[m] = r[g+k];
                            m = m + 1;
                        end
                    end
                end
            end
            if (n > 2) begin
                r = nx;
                n = m;
            end
        end
        sum = r[0];
        carry = (n > 1) ? r[1] : '0;
    end
endmodule

// File: rtl/wallace_mult_pipe.sv
// wallace_mult_pipe: 3-stage pipelined Wallace-tree multiplier with valid/ready flow control
// `define MULT_SIGNED_EN adds port sgn selecting Baugh-Wooley two's-complement operation
module wallace_mult_pipe
    import mult_pkg::*;
#(
    parameter int W = W_DEF,
    parameter int OUT_W = 2 * W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W-1:0]     A,
    input  logic [W-1:0]     B,
`ifdef MULT_SIGNED_EN
    input  logic             sgn,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] prod
);
    logic             s;
    logic             stall;
    logic [LATENCY-1:0] v;
    pp_row_t          pp_d  [W];
    pp_row_t          pp1   [W];
    logic [OUT_W-1:0] red_s, red_c, sum2, car2;
`ifdef MULT_SIGNED_EN
    assign s = sgn;
`else
    assign s = 1'b0;
`endif
    assign stall = out_valid && !out_ready;
    assign in_ready = !stall;
    assign out_valid = v[LATENCY-1];
    // signed mode inverts the cross terms touching exactly one sign bit and adds 2^W + 2^(2W-1)
    always_comb begin
        for (int i = 0; i < W; i++) begin
            pp_d[i] = '0;
            for (int j = 0; j < W; j++)
                pp_d[i][i+j] = (A[j] & B[i]) ^ (s & ((i == W-1) != (j == W-1)));
        end
        pp_d[0][W] = s;
        pp_d[0][2*W-1] = s;
    end
    wallace_reduce #(.W(W), .OUT_W(OUT_W)) u_reduce (
        .pp    (pp1),
        .sum   (red_s),
        .carry (red_c)
    );
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v <= '0;
            pp1 <= '{default: '0};
            sum2 <= '0;
            car2 <= '0;
            prod <= '0;
        end else if (!stall) begin
            v <= {v[LATENCY-2:0], in_valid};
            if (in_valid) pp1 <= pp_d;
            if (v[0]) begin
                sum2 <= red_s;
                car2 <= red_c;
            end
            if (v[1]) prod <= sum2 + car2;
        end
    end
endmodule

// File: tb/tb_wallace_mult_pipe.sv
// tb_wallace_mult_pipe: scoreboard bench for W=4, 8 and 16 instances with directed and random traffic
module tb_wallace_mult_pipe;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic iv0, ir0, ov0, or0;
    logic [3:0] a0, b0;
    logic [7:0] p0;
    logic iv1, ir1, ov1, or1;
    logic [7:0] a1, b1;
    logic [15:0] p1;
    logic iv2, ir2, ov2, or2;
    logic [15:0] a2, b2;
    logic [31:0] p2;
    logic sg;
    int checks, errors;
    longint unsigned q [3][$];
    longint unsigned last [3];
    int rx [3];
    int tx [3];
    bit cv, cr, civ, cir, cer;
    longint unsigned cp, ca, cb;
    int cw;

    always #5 clk = ~clk;

    wallace_mult_pipe #(.W(4)) u4 (
        .clk(clk), .rst(rst), .in_valid(iv0), .in_ready(ir0), .A(a0), .B(b0),
`ifdef MULT_SIGNED_EN
        .sgn(1'b0),
`endif
        .out_valid(ov0), .out_ready(or0), .prod(p0)
    );
    wallace_mult_pipe #(.W(8)) u8 (
        .clk(clk), .rst(rst), .in_valid(iv1), .in_ready(ir1), .A(a1), .B(b1),
`ifdef MULT_SIGNED_EN
        .sgn(sg),
`endif
        .out_valid(ov1), .out_ready(or1), .prod(p1)
    );
    wallace_mult_pipe #(.W(16)) u16 (
        .clk(clk), .rst(rst), .in_valid(iv2), .in_ready(ir2), .A(a2), .B(b2),
`ifdef MULT_SIGNED_EN
        .sgn(1'b0),
`endif
        .out_valid(ov2), .out_ready(or2), .prod(p2)
    );

    task automatic chk(input bit ok, input string nm, input longint unsigned act, input longint unsigned exp);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s got %0d want %0d at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic longint unsigned mul(input int w, input longint unsigned a, input longint unsigned b, input bit s);
        longint sa, sb;
        longint unsigned msk;
        msk = (64'd1 << (2 * w)) - 64'd1;
        sa = (s && a[w-1]) ? longint'(a) - (longint'(1) << w) : longint'(a);
        sb = (s && b[w-1]) ? longint'(b) - (longint'(1) << w) : longint'(b);
        return longint'(sa * sb) & msk;
    endfunction

    // the model: expected in_ready from the stall rule, FIFO of products in acceptance order
    always @(negedge clk) begin
        for (int d = 0; d < 3; d++) begin
            cv  = d == 0 ? ov0 : d == 1 ? ov1 : ov2;
            cr  = d == 0 ? or0 : d == 1 ? or1 : or2;
            civ = d == 0 ? iv0 : d == 1 ? iv1 : iv2;
            cir = d == 0 ? ir0 : d == 1 ? ir1 : ir2;
            cp  = d == 0 ? longint'(p0) : d == 1 ? longint'(p1) : longint'(p2);
            ca  = d == 0 ? longint'(a0) : d == 1 ? longint'(a1) : longint'(a2);
            cb  = d == 0 ? longint'(b0) : d == 1 ? longint'(b1) : longint'(b2);
            cw  = d == 0 ? 4 : d == 1 ? 8 : 16;
            if (rst) begin
                q[d].delete();
                last[d] = 0;
            end else begin
                cer = !(cv && !cr);
                chk(cir == cer, "in_ready", longint'(cir), longint'(cer));
                if (cv) begin
                    if (q[d].size() == 0) chk(1'b0, "spurious_out_valid", cp, 0);
                    else begin
                        chk(cp == q[d][0], "prod", cp, q[d][0]);
                        if (cr) begin
                            last[d] = q[d].pop_front();
                            rx[d]++;
                        end
                    end
                end else chk(cp == last[d], "idle_prod", cp, last[d]);
                if (civ && cer) begin
                    q[d].push_back(mul(cw, ca, cb, d == 1 && sg));
                    tx[d]++;
                end
            end
        end
    end

    initial begin
        checks = 0; errors = 0;
        for (int d = 0; d < 3; d++) begin rx[d] = 0; tx[d] = 0; last[d] = 0; end
        iv0 = 0; iv1 = 0; iv2 = 0; or0 = 1; or1 = 1; or2 = 1;
        a0 = 0; b0 = 0; a1 = 0; b1 = 0; a2 = 0; b2 = 0; sg = 0;
        #1;
        chk(ov0 == 0 && p0 == 0, "rst_w4", p0, 0);
        chk(ov1 == 0 && p1 == 0, "rst_w8", p1, 0);
        chk(ov2 == 0 && p2 == 0, "rst_w16", p2, 0);
        chk(ir0 && ir1 && ir2, "rst_in_ready", {ir0, ir1, ir2}, 7);
        @(negedge clk); rst = 0;
        // W=4 exhaustive, back to back
        for (int i = 0; i < 262; i++) begin
            @(posedge clk); #1;
            if (i == 2) chk(ov0 == 0, "w4_not_early", ov0, 0);
            if (i == 3) chk(ov0 && p0 == 8'd225, "w4_first_at_3", p0, 225);
            if (i == 4) chk(ov0 && p0 == 8'd210, "w4_second", p0, 210);
            iv0 = i < 256;
            a0 = 4'(15 - i % 16);
            b0 = 4'(15 - (i / 16) % 16);
        end
        iv0 = 0;
        chk(rx[0] == 256, "w4_count", rx[0], 256);
        // W=8 max operands
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1;
            if (k == 2) chk(ov1 == 0, "w8_max_early", ov1, 0);
            if (k == 3) chk(ov1 && p1 == 16'hFE01, "w8_max", p1, 65025);
            iv1 = k == 0; a1 = 8'd255; b1 = 8'd255;
        end
        iv1 = 0;
        // W=8 stall for 5 cycles with 3 in flight
        or1 = 0;
        for (int k = 0; k < 11; k++) begin
            @(posedge clk); #1;
            if (k >= 3 && k <= 7) begin
                chk(ov1 && p1 == 16'd200, "stall_hold", p1, 200);
                chk(ir1 == 0, "stall_in_ready", ir1, 0);
            end
            if (k == 7) or1 = 1;
            if (k == 8) chk(ov1 && p1 == 16'd21, "stall_second", p1, 21);
            if (k == 9) chk(ov1 && p1 == 16'd510, "stall_third", p1, 510);
            if (k == 10) chk(ov1 == 0, "stall_drained", ov1, 0);
            iv1 = k < 3;
            a1 = k == 0 ? 8'd10 : k == 1 ? 8'd3 : 8'd255;
            b1 = k == 0 ? 8'd20 : k == 1 ? 8'd7 : 8'd2;
        end
        iv1 = 0;
        // W=8 out_ready toggling every cycle
        for (int k = 0; k < 24; k++) begin
            @(posedge clk); #1;
            or1 = k[0];
            iv1 = k < 10;
            a1 = 8'(k * 37 + 1);
            b1 = 8'(200 - k * 13);
        end
        or1 = 1;
        repeat (6) @(posedge clk);
        #1 chk(q[1].size() == 0, "toggle_drain", q[1].size(), 0);
        // reset with two operands in flight
        for (int k = 0; k < 2; k++) begin
            @(posedge clk); #1;
            iv1 = 1; a1 = k == 0 ? 8'd7 : 8'd11; b1 = k == 0 ? 8'd9 : 8'd13;
        end
        @(posedge clk); #1 iv1 = 0;
        #2 rst = 1;
        #1;
        chk(ov1 == 0 && p1 == 0, "midrst_clear", p1, 0);
        chk(ir1 == 1, "midrst_in_ready", ir1, 1);
        @(posedge clk); #2 rst = 0;
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1;
            chk(ov1 == 0, "midrst_no_stale", ov1, 0);
        end
`ifdef MULT_SIGNED_EN
        for (int t = 0; t < 2; t++) begin
            for (int k = 0; k < 5; k++) begin
                @(posedge clk); #1;
                if (k == 3 && t == 0) chk(ov1 && p1 == 16'hFFF1, "signed_m3x5", p1, 16'hFFF1);
                if (k == 3 && t == 1) chk(ov1 && p1 == 16'h04F1, "unsigned_253x5", p1, 1265);
                iv1 = k == 0; sg = t == 0; a1 = 8'hFD; b1 = 8'd5;
            end
        end
        iv1 = 0; sg = 0;
`endif
        // W=16 random handshakes
        for (int k = 0; k < 10000; k++) begin
            @(posedge clk); #1;
            iv2 = 1'($urandom_range(0, 1));
            or2 = 1'($urandom_range(0, 1));
            a2 = ($urandom_range(0, 15) == 0) ? 16'hFFFF : 16'($urandom);
            b2 = ($urandom_range(0, 15) == 0) ? 16'hFFFF : 16'($urandom);
        end
        iv2 = 0; or2 = 1;
        repeat (8) @(posedge clk);
        #1;
        chk(q[2].size() == 0, "w16_no_drop", q[2].size(), 0);
        chk(rx[2] == tx[2], "w16_count", rx[2], tx[2]);
        chk(tx[2] > 1000, "w16_traffic", tx[2], 1000);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/wallace_mult_pipe.md
WALLACE_MULT_PIPE -- requirements
Module: wallace_mult_pipe

Interface
REQ-001 SHALL have parameter W, default 8, operand width; legal range 2..16.
REQ-002 SHALL have parameter OUT_W, default 2*W, product width; derived, not overridden.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port in_valid  input  1  operand pair A/B present.
REQ-006 SHALL have port in_ready  output  1  block accepts operand pair this cycle.
REQ-007 SHALL have port A  input  W  multiplicand.
REQ-008 SHALL have port B  input  W  multiplier.
REQ-009 SHALL have port out_valid  output  1  prod holds a valid result.
REQ-010 SHALL have port out_ready  input  1  downstream accepts prod this cycle.
REQ-011 SHALL have port prod  output  OUT_W  product A*B.

Function
REQ-012 SHALL accept an operand pair on a rising edge where in_valid && in_ready.
REQ-013 SHALL use a 3-stage pipeline: S1 registers A/B and the W partial-product rows; S2 registers the two carry-save rows from Wallace reduction; S3 registers the final carry-propagate sum to prod.
REQ-014 SHALL assert out_valid exactly 3 cycles after acceptance when there is no stall.
REQ-015 SHALL define stall = out_valid && !out_ready; while stalled, all stage registers and valid bits SHALL hold.
REQ-016 SHALL drive in_ready = !stall, combinationally.
REQ-017 SHALL propagate a per-stage valid bit; bubbles (in_valid=0) SHALL advance as invalid slots and never produce out_valid.
REQ-018 SHALL sustain one result per cycle under continuous in_valid and out_ready=1.
REQ-019 SHALL hold prod and out_valid stable from assertion until out_ready is sampled high.
REQ-020 SHALL compute prod exactly; no truncation or saturation. Max unsigned result (2^W-1)^2 SHALL fit in OUT_W.
REQ-021 SHALL preserve acceptance order; results SHALL never reorder or duplicate.
REQ-022 SHALL handle out_ready toggling every cycle without losing or repeating results.
REQ-023 SHALL keep prod's data value undefined-free: prod SHALL equal the last valid result, or 0 after reset, when out_valid=0.

Reset
REQ-024 SHALL clear all valid bits and out_valid to 0, and prod and all stage data to 0, asynchronously on rst=1.
REQ-025 SHALL discard in-flight operands on reset mid-operation; no result for them SHALL appear after rst deasserts.
REQ-026 SHALL drive in_ready=1 during and immediately after reset.

Configuration
REQ-027 SHALL use macro MULT_SIGNED_EN: when defined, add port sgn  input  1, sampled with A/B; sgn=1 treats A, B and prod as two's complement (Baugh-Wooley partial products), and sgn=0 is unsigned.
REQ-028 SHALL, without MULT_SIGNED_EN, omit port sgn and treat all operands as unsigned; pipeline latency is identical in both builds.

Structure
REQ-029 SHALL place the default W, the LATENCY=3 constant and the partial-product row typedef in shared package mult_pkg.
REQ-030 SHALL implement the reduction tree as combinational sub-module wallace_reduce (inputs: PP rows; outputs: sum and carry rows, OUT_W each), instantiated between S1 and S2.
REQ-031 SHALL be reusable by the existing 4-bit testbench flow at W=4 with identical product results.

Verification
REQ-032 SHALL pass: W=4, exhaustive 256 pairs back-to-back, out_ready=1 -> 256 results in order, each prod == A*B, first at cycle 3.
REQ-033 SHALL pass: W=8, A=255, B=255 -> prod=65025 (16'hFE01) after 3 cycles.
REQ-034 SHALL pass: W=8, stream 3 pairs and hold out_ready=0 for 5 cycles -> in_ready=0 while stalled, prod holds the first result, and all 3 results appear in order after release.
REQ-035 SHALL pass: assert rst with 2 operands in flight -> out_valid=0 and prod=0 immediately; no stale result appears within 5 cycles after release.
REQ-036 SHALL pass, with MULT_SIGNED_EN, W=8: A=-3 (8'hFD), B=5, sgn=1 -> prod=16'hFFF1 (-15); same operands with sgn=0 -> prod=1265 (16'h04F1).
REQ-037 SHALL pass: random in_valid/out_ready at 50% each for 10k cycles, W=16 -> scoreboard matches every result and shows no drops or duplicates.
